byte_state_collector: RTL and testbench

- Consumer end of the byte-serial datapath: takes the 8-bit stream leaving the byte-permutation stage (ShiftRows / InvShiftRows) and reassembles 16 bytes into a 128-bit AES state.
- Presents the assembled state on a valid/ready handshake to the word-parallel stages (MixColumns / AddRoundKey / key compare).
- Supports column-major or transposed (row-major) packing, selected per block.

---
 rtl/aes_stream_pkg.sv | 19 +
 rtl/byte_slot_index.sv | 30 +++
 rtl/byte_state_collector.sv | 225 ++++++++++++++++++++++
 tb/tb_byte_state_collector.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_pkg.sv
// Shared definitions for the byte-serial AES datapath: block geometry,
// collector FSM states and byte packing modes.
package aes_stream_pkg;

  localparam int unsigned AES_NB_BYTES = 16;
  localparam int unsigned AES_BYTE_W   = 8;
  localparam int unsigned AES_STATE_W  = AES_NB_BYTES * AES_BYTE_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } collector_state_e;

  // Packing modes: column-major keeps stream order, row-major transposes the 4x4 matrix.
  localparam logic PACK_COL = 1'b0;
  localparam logic PACK_ROW = 1'b1;

endpackage

// File: rtl/byte_slot_index.sv
// Maps a stream byte number k to its slot in the assembled state for the
// selected packing mode. Purely combinational; shared with the serializer.
module byte_slot_index
  import aes_stream_pkg::*;
#(
  parameter int unsigned NUM_BYTES = AES_NB_BYTES,
  parameter int unsigned CntW      = $clog2(NUM_BYTES)
) (
  input  logic [CntW-1:0] k_i,
  input  logic            mode_i,
  output logic [CntW-1:0] slot_o
);

  localparam int unsigned Rows = 4;
  localparam int unsigned Cols = NUM_BYTES / Rows;

  logic [31:0] k_w;

  assign k_w = 32'(k_i);

  // Row-major: byte k lands in row (k mod 4), column (k / 4) of the transposed layout.
  always_comb begin
    if (mode_i == PACK_ROW) begin
      slot_o = CntW'((k_w % Rows) * Cols + k_w / Rows);
    end else begin
      slot_o = k_i;
    end
  end

endmodule

// File: rtl/byte_state_collector.sv
// Reassembles a byte stream from the permutation stage into a full AES state
// and offers it downstream on a valid/ready handshake.
// Optional: define BYTE_COLLECT_DBUF_EN to add a shadow buffer that keeps
// collecting while a completed block waits in HOLD.
module byte_state_collector
  import aes_stream_pkg::*;
#(
  parameter int unsigned NUM_BYTES = AES_NB_BYTES,
  parameter int unsigned DATA_W    = AES_BYTE_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        mode,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        in_valid,
  output logic [NUM_BYTES*DATA_W-1:0] out_state,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        overflow
);

  localparam int unsigned     StateW  = NUM_BYTES * DATA_W;
  localparam int unsigned     CntW    = $clog2(NUM_BYTES);
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_BYTES - 1);

  collector_state_e  state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic [StateW-1:0] buf_q, buf_d;

  logic [CntW-1:0]   eff_cnt;
  logic              eff_mode;
  logic [CntW-1:0]   slot;
  logic [31:0]       slot_msb;
  logic              handshake;

  assign handshake = (state_q == HOLD) && out_ready;

  // A start strobe outside HOLD restarts the block at byte 0 in the newly requested mode.
  always_comb begin
    eff_cnt  = cnt_q;
    eff_mode = mode_q;
    if (en && (state_q != HOLD)) begin
      eff_cnt  = '0;
      eff_mode = mode;
    end
  end

  byte_slot_index #(
    .NUM_BYTES(NUM_BYTES),
    .CntW     (CntW)
  ) u_slot (
    .k_i   (eff_cnt),
    .mode_i(eff_mode),
    .slot_o(slot)
  );

  assign slot_msb = StateW - 1 - DATA_W * 32'(slot);

`ifdef BYTE_COLLECT_DBUF_EN
  logic              sh_armed_q, sh_armed_d;
  logic              sh_full_q, sh_full_d;
  logic [CntW-1:0]   sh_cnt_q, sh_cnt_d;
  logic              sh_mode_q, sh_mode_d;
  logic [StateW-1:0] sh_buf_q, sh_buf_d;

  logic              sh_nxt_armed, sh_nxt_full, sh_nxt_mode;
  logic [CntW-1:0]   sh_nxt_cnt;
  logic [StateW-1:0] sh_nxt_buf;
  logic              sh_take_en, sh_active, sh_drop, sh_eff_mode;
  logic [CntW-1:0]   sh_eff_cnt, sh_slot;
  logic [31:0]       sh_slot_msb;

  // En in HOLD arms the shadow unless it already holds a finished block.
  always_comb begin
    sh_take_en  = (state_q == HOLD) && en && !sh_full_q;
    sh_active   = sh_armed_q || sh_take_en;
    sh_eff_cnt  = sh_take_en ? '0 : sh_cnt_q;
    sh_eff_mode = sh_take_en ? mode : sh_mode_q;
  end

  byte_slot_index #(
    .NUM_BYTES(NUM_BYTES),
    .CntW     (CntW)
  ) u_sh_slot (
    .k_i   (sh_eff_cnt),
    .mode_i(sh_eff_mode),
    .slot_o(sh_slot)
  );

  assign sh_slot_msb = StateW - 1 - DATA_W * 32'(sh_slot);

  // Shadow collection while HOLD; a handshake hands its contents to the main path.
  always_comb begin
    sh_nxt_armed = sh_armed_q;
    sh_nxt_full  = sh_full_q;
    sh_nxt_cnt   = sh_cnt_q;
    sh_nxt_mode  = sh_mode_q;
    sh_nxt_buf   = sh_buf_q;
    sh_drop      = 1'b0;
    if (state_q == HOLD) begin
      sh_nxt_armed = sh_active;
      sh_nxt_cnt   = sh_eff_cnt;
      sh_nxt_mode  = sh_eff_mode;
      if (in_valid) begin
        if (sh_full_q) begin
          sh_drop = 1'b1;
        end else if (sh_active) begin
          sh_nxt_buf[sh_slot_msb -: DATA_W] = data_in;
          if (sh_eff_cnt == LastCnt) begin
            sh_nxt_full  = 1'b1;
            sh_nxt_armed = 1'b0;
            sh_nxt_cnt   = '0;
          end else begin
            sh_nxt_cnt = sh_eff_cnt + 1'b1;
          end
        end
      end
    end
    sh_armed_d = handshake ? 1'b0 : sh_nxt_armed;
    sh_full_d  = handshake ? 1'b0 : sh_nxt_full;
    sh_cnt_d   = handshake ? '0 : sh_nxt_cnt;
    sh_mode_d  = sh_nxt_mode;
    sh_buf_d   = sh_nxt_buf;
  end

  // Shadow buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_armed_q <= 1'b0;
      sh_full_q  <= 1'b0;
      sh_cnt_q   <= '0;
      sh_mode_q  <= PACK_COL;
      sh_buf_q   <= '0;
    end else begin
      sh_armed_q <= sh_armed_d;
      sh_full_q  <= sh_full_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_mode_q  <= sh_mode_d;
      sh_buf_q   <= sh_buf_d;
    end
  end
`endif

  // Next state, counter, mode latch and byte placement into the main buffer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    buf_d    = buf_q;
    overflow = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = COLLECT;
          cnt_d   = eff_cnt;
          mode_d  = eff_mode;
        end
      end
      COLLECT: begin
        cnt_d  = eff_cnt;
        mode_d = eff_mode;
      end
      HOLD: begin
`ifdef BYTE_COLLECT_DBUF_EN
        overflow = sh_drop;
        if (handshake) begin
          if (sh_nxt_full) begin
            buf_d = sh_nxt_buf;
          end else if (sh_nxt_armed) begin
            buf_d   = sh_nxt_buf;
            cnt_d   = sh_nxt_cnt;
            mode_d  = sh_nxt_mode;
            state_d = COLLECT;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
`else
        overflow = in_valid;
        if (handshake) begin
          state_d = en ? COLLECT : IDLE;
          cnt_d   = '0;
          if (en) begin
            mode_d = mode;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (in_valid && ((state_q == COLLECT) || ((state_q == IDLE) && en))) begin
      buf_d[slot_msb -: DATA_W] = data_in;
      if (eff_cnt == LastCnt) begin
        state_d = HOLD;
        cnt_d   = '0;
      end else begin
        cnt_d = eff_cnt + 1'b1;
      end
    end
  end

  // Main state, counter, mode latch and assembled block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= PACK_COL;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      buf_q   <= buf_d;
    end
  end

  assign out_state = buf_q;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == COLLECT);

endmodule

// File: tb/tb_byte_state_collector.sv
// Scoreboard bench for byte_state_collector: stimulus pushes expected blocks,
// a monitor drives out_ready and checks each accepted block.
module tb_byte_state_collector;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic [7:0]   data_in = 8'h00;
  logic         in_valid = 1'b0;
  logic [127:0] out_state;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         overflow;

  int checks = 0;
  int failures = 0;

  logic [127:0] exp_q[$];
  int issued = 0;
  int accepted = 0;
  bit hs_pending = 0;
  bit hold_low = 0;
  bit force_rdy = 0;

  byte_state_collector dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .data_in  (data_in),
    .in_valid (in_valid),
    .out_state(out_state),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference packing: mode 1 is the transpose of the 4x4 byte matrix.
  function automatic logic [127:0] pack_ref(input logic m, input logic [7:0] b [16]);
    logic [127:0] r;
    int slot;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      slot = m ? (4 * (k % 4) + k / 4) : k;
      r[127 - 8 * slot -: 8] = b[k];
    end
    return r;
  endfunction

  // Monitor: pick out_ready each cycle, check the block on every handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        out_ready = 1'b0;
      end else begin
        out_ready = hold_low ? 1'b0 : (force_rdy ? 1'b1 : ($urandom_range(0, 2) != 0));
        #1;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_block actual=%h required=none", out_state);
          end else begin
            check("block", out_state, exp_q.pop_front());
          end
          hs_pending = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (hs_pending) begin
        accepted++;
        hs_pending = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (issued != accepted && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (issued != accepted) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=%0d", accepted, issued);
    end
  endtask

  task automatic send_block(input logic m, input logic [7:0] b [16], input logic [127:0] exp);
    int k0;
    bit join_first;
    wait_idle();
    join_first = 1'($urandom_range(0, 1));
    en   = 1'b1;
    mode = m;
    if (join_first) begin
      in_valid = 1'b1;
      data_in  = b[0];
      k0       = 1;
    end else begin
      in_valid = 1'b0;
      k0       = 0;
    end
    @(posedge clk);
    #1;
    en       = 1'b0;
    in_valid = 1'b0;
    for (int k = k0; k < 16; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      data_in  = b[k];
      if (k == 15) begin
        check("valid_before_last", out_valid, 0);
        check("busy_collect", busy, 1);
        check("overflow_collect", overflow, 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    exp_q.push_back(exp);
    issued++;
    check("valid_latency", out_valid, 1);
    check("busy_hold", busy, 0);
  endtask

  task automatic junk(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      data_in  = 8'($urandom);
      @(negedge clk);
      #2;
      check("overflow", overflow, in_valid && (issued > accepted));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [7:0]   b [16];
    logic [127:0] bp_exp;
    logic         m;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", out_state, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Stray byte in IDLE is ignored silently
    in_valid = 1'b1;
    data_in  = 8'h55;
    @(negedge clk);
    #2;
    check("idle_overflow", overflow, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);

    // Directed packing
    for (int k = 0; k < 16; k++) b[k] = 8'(k);
    send_block(1'b0, b, 128'h000102030405060708090a0b0c0d0e0f);
    send_block(1'b1, b, 128'h0004080c0105090d02060a0e03070b0f);

    // Backpressure with a dropped byte and an ignored en during HOLD
    wait_idle();
    hold_low = 1;
    bp_exp   = 128'h000102030405060708090a0b0c0d0e0f;
    send_block(1'b0, b, bp_exp);
    for (int c = 1; c <= 10; c++) begin
      if (c == 3) begin
        in_valid = 1'b1;
        data_in  = 8'haa;
      end
      if (c == 5) en = 1'b1;
      @(negedge clk);
      #2;
      check("bp_valid", out_valid, 1);
      check("bp_state", out_state, bp_exp);
      check("bp_busy", busy, 0);
      check("bp_overflow", overflow, (c == 3));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      en       = 1'b0;
    end
    hold_low  = 0;
    force_rdy = 1;
    @(posedge clk);
    #1;
    check("bp_after_valid", out_valid, 0);
    check("bp_after_busy", busy, 0);
    check("bp_retained", out_state, bp_exp);
    force_rdy = 0;

    // Abort after 5 bytes, then a fresh block
    en   = 1'b1;
    mode = 1'b0;
    @(posedge clk);
    #1;
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      data_in  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) b[k] = 8'(8'h10 + k);
    send_block(1'b0, b, 128'h101112131415161718191a1b1c1d1e1f);

    // Randomized blocks, some aborted, with stray bytes between
    for (int n = 0; n < 30; n++) begin
      m = 1'($urandom_range(0, 1));
      for (int k = 0; k < 16; k++) b[k] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        en   = 1'b1;
        mode = ~m;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat ($urandom_range(1, 10)) begin
          in_valid = 1'b1;
          data_in  = 8'($urandom);
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
      end
      send_block(m, b, pack_ref(m, b));
      junk($urandom_range(0, 4));
    end
    wait_idle();

    // Asynchronous reset mid-collect
    en   = 1'b1;
    mode = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      data_in  = 8'($urandom_range(1, 255));
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b0;
    #1;
    check("arst_state", out_state, 0);
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      data_in  = 8'($urandom);
      check("post_rst_valid", out_valid, 0);
      check("post_rst_busy", busy, 0);
    end
    in_valid = 1'b0;
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
